uart_echo_fifo: RTL
===================

# uart_echo_fifo

Buffered, parametrised UART echo engine sitting between the receive and transmit byte interfaces of `uart_top`. Received bytes are captured on the rising edge of the RX valid strobe, optionally case-transformed, queued in an internal FIFO, and replayed to the transmitter one byte at a time using the `i_tx_dv` / `o_tx_done` handshake. Replay is either per byte or per line (held until a terminator arrives). Overflow is counted rather than silently lost.

## Interface
- `DEPTH`, 16: FIFO depth in bytes; power of two, ≥ 2.
- `LINE_MODE`, 0: 0 = forward each byte as soon as it is queued; 1 = forward only complete lines.
- `TERM_BYTE`, 8'h0D: line terminator compared against the raw received byte.
- `TRANSFORM`, 0: 0 = none; 1 = a–z to upper case; 2 = A–Z to lower case. Non-letters pass unchanged.
- `DROP_CNT_W`, 16: width of the drop counter.

Ports:
- `i_clk` in 1: system clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_rx_dv` in 1: RX byte valid; may be held high for several cycles.
- `i_rx_byte` in 8: RX data, valid while `i_rx_dv` is high.
- `i_tx_active` in 1: transmitter busy.
- `i_tx_done` in 1: one-cycle pulse at the end of a transmitted byte.
- `i_clr_stat` in 1: synchronous clear of `o_overflow` and `o_drop_cnt`.
- `o_tx_dv` out 1: one-cycle transmit request.
- `o_tx_byte` out 8: transmit data, stable from the `o_tx_dv` cycle until the next load.
- `o_fifo_count` out $clog2(DEPTH)+1: current occupancy.
- `o_fifo_empty` out 1: occupancy is 0.
- `o_fifo_full` out 1: occupancy equals DEPTH.
- `o_overflow` out 1: sticky; set by any dropped byte.
- `o_drop_cnt` out DROP_CNT_W: dropped-byte count; saturates at all-ones.

## Operation
- **RX capture:** a registered copy of `i_rx_dv` provides edge detection. A write occurs only when `i_rx_dv` is high and the registered copy is low. A held `i_rx_dv` produces exactly one write.
- **Dropping:** a write when the FIFO is full is dropped, sets `o_overflow`, and increments `o_drop_cnt`. This holds even if a pop occurs in the same cycle.
- **Transform:** `TRANSFORM` is applied before the byte is stored.
- **Terminator count:** `term_cnt` (width of `o_fifo_count`) increments on each accepted write whose raw byte equals `TERM_BYTE`. It decrements when a popped byte equals the terminator. A simultaneous increment and decrement leaves it unchanged.
- **TX FSM states:** IDLE, READ, SEND, WAIT.
- **IDLE → READ** when all of the following hold:
  - FIFO not empty;
  - `i_tx_active` low;
  - send is permitted: always when `LINE_MODE` = 0; when `LINE_MODE` = 1, only if `term_cnt` > 0 or the FIFO is full.
- **READ:** pops one entry (synchronous read). Always moves to SEND.
- **SEND:** loads `o_tx_byte` and drives `o_tx_dv` high for exactly this cycle. Moves to WAIT.
- **WAIT:** moves to IDLE on `i_tx_done`.
- **Line flush:** in `LINE_MODE` = 1, a flush continues through IDLE until the terminator has been sent or the FIFO is empty. A full FIFO with no terminator flushes until empty.
- **`i_clr_stat`:** clears both statistics. A drop in the same cycle wins, leaving `o_overflow` = 1 and `o_drop_cnt` = 1.

## Timing
- **Reset values:**
  - `o_tx_dv` 0
  - `o_tx_byte` 8'h00
  - `o_fifo_count` 0
  - `o_fifo_empty` 1
  - `o_fifo_full` 0
  - `o_overflow` 0
  - `o_drop_cnt` 0
  - FSM in IDLE, `term_cnt` 0, pointers 0
- **Reset mid-operation:** reset during WAIT abandons the byte held by `uart_top`. FIFO contents are discarded.
- **Write latency:** the capture edge is edge E. `o_fifo_count` reflects the write after edge E.
- **Byte-mode echo latency:** into an empty FIFO with the TX idle:
  - edge E+1: IDLE → READ;
  - edge E+2: `o_tx_byte` valid and `o_tx_dv` = 1;
  - edge E+3: `o_tx_dv` = 0.
- **Back-to-back bytes:** the next `o_tx_dv` occurs no earlier than 2 cycles after `i_tx_done`.
- **Pointer wrap:** pointers are $clog2(DEPTH) bits and wrap naturally.

## Structure
- Package `uart_pkg`: FSM state enum `tx_state_e`, transform encodings (`XF_NONE`, `XF_UPPER`, `XF_LOWER`), and the function `xform_byte()`.
- Sub-module `sync_fifo`: parameters WIDTH and DEPTH; synchronous read; exposes count, full and empty; push when full is ignored.
- The top-level connection to `uart_top` is made by the board wrapper, not inside this block.

## Test plan
- **Byte echo:** `LINE_MODE` = 0, `TRANSFORM` = 0. `i_rx_dv` held for 5 cycles with 8'h41 → exactly one `o_tx_dv`, with 8'h41, 2 cycles after the rising edge.
- **Upper-case transform:** `TRANSFORM` = 1. Send "aZ1" → transmitted 8'h41, 8'h5A, 8'h31, in order, each after the prior `i_tx_done`.
- **Line mode:** `LINE_MODE` = 1. Send "ab" → no `o_tx_dv`. Then send 8'h0D → 8'h61, 8'h62, 8'h0D are transmitted, `term_cnt` returns to 0, and the FSM stays idle.
- **Overflow:** `DEPTH` = 4 with `i_tx_active` held high. Send 6 bytes → `o_fifo_full` = 1, `o_drop_cnt` = 2, `o_overflow` = 1. After `i_clr_stat` → both 0 and FIFO contents intact.
- **Full flush and wrap:** `LINE_MODE` = 1, `DEPTH` = 4, no terminator. Send 4 bytes → all 4 flushed. Then send 3 more bytes plus terminator → all 4 flushed, checking pointer wrap.
- **Reset mid-operation:** assert `i_rst` during WAIT with 3 bytes queued → all outputs at reset values immediately, and no `o_tx_dv` after release until new RX input.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and the byte case-transform helper for the UART echo engine.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    WAIT
  } tx_state_e;

  localparam int XF_NONE  = 0;
  localparam int XF_UPPER = 1;
  localparam int XF_LOWER = 2;

  function automatic logic [7:0] xform_byte(input logic [7:0] b, input int mode);
    logic [7:0] r;
    r = b;
    if (mode == XF_UPPER && b >= 8'h61 && b <= 8'h7A) begin
      r = b - 8'h20;
    end else if (mode == XF_LOWER && b >= 8'h41 && b <= 8'h5A) begin
      r = b + 8'h20;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; pushes while full are ignored,
// pops while empty are ignored.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: captures RX bytes on the valid strobe's rising edge, queues
// them and replays them to the transmitter per byte or per complete line.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         LINE_MODE  = 0,
  parameter logic [7:0] TERM_BYTE  = 8'h0D,
  parameter int         TRANSFORM  = XF_NONE,
  parameter int         DROP_CNT_W = 16,
  localparam int        CW         = $clog2(DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_dv,
  input  logic [7:0]            i_rx_byte,
  input  logic                  i_tx_active,
  input  logic                  i_tx_done,
  input  logic                  i_clr_stat,
  output logic                  o_tx_dv,
  output logic [7:0]            o_tx_byte,
  output logic [CW-1:0]         o_fifo_count,
  output logic                  o_fifo_empty,
  output logic                  o_fifo_full,
  output logic                  o_overflow,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  tx_state_e     state;
  logic          rx_dv_q;
  logic          wr;
  logic          drop;
  logic          push;
  logic          pop;
  logic          is_term;
  logic [8:0]    push_data;
  logic [8:0]    pop_data;
  logic [CW-1:0] term_cnt;
  logic          term_inc;
  logic          term_dec;
  logic          flushing;
  logic          send_ok;
  logic          go;

  assign wr        = i_rx_dv && !rx_dv_q;
  assign drop      = wr && o_fifo_full;
  assign push      = wr && !o_fifo_full;
  assign pop       = (state == READ);
  assign is_term   = (i_rx_byte == TERM_BYTE);
  // Bit 8 remembers whether the raw byte was the terminator, since the
  // transform may change how the stored byte looks.
  assign push_data = {is_term, xform_byte(i_rx_byte, TRANSFORM)};
  assign o_tx_byte = pop_data[7:0];

  assign term_inc = push && is_term;
  assign term_dec = (state == SEND) && pop_data[8];
  assign send_ok  = (LINE_MODE == 0) || (term_cnt != '0) || o_fifo_full || flushing;
  assign go       = !o_fifo_empty && !i_tx_active && send_ok;

  sync_fifo #(
    .WIDTH(9),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (pop_data),
    .count    (o_fifo_count),
    .full     (o_fifo_full),
    .empty    (o_fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_dv_q  <= 1'b0;
      term_cnt <= '0;
    end else begin
      rx_dv_q <= i_rx_dv;
      case ({term_inc, term_dec})
        2'b10:   term_cnt <= term_cnt + 1'b1;
        2'b01:   term_cnt <= term_cnt - 1'b1;
        default: term_cnt <= term_cnt;
      endcase
    end
  end

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (i_clr_stat)       o_drop_cnt <= DROP_CNT_W'(1);
      else if (!(&o_drop_cnt)) o_drop_cnt <= o_drop_cnt + 1'b1;
    end else if (i_clr_stat) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      o_tx_dv  <= 1'b0;
      flushing <= 1'b0;
    end else begin
      o_tx_dv <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state    <= READ;
            flushing <= (LINE_MODE != 0);
          end else if (o_fifo_empty) begin
            flushing <= 1'b0;
          end
        end
        READ: begin
          state   <= SEND;
          o_tx_dv <= 1'b1;
        end
        SEND: begin
          state <= WAIT;
          if (pop_data[8]) flushing <= 1'b0;
        end
        WAIT: begin
          if (i_tx_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
